// File: rtl/tt_bitwise_lane_unit_if.sv
// Valid/ready stream bundle for tt_bitwise_lane_unit: operand beats in, registered results out.
// The master drives beats and out_ready; the slave (the lane unit) drives results and in_ready.
interface tt_bitwise_lane_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    localparam int PCW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic [PCW-1:0]   out_popcnt;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_popcnt, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_popcnt, out_count
    );
endinterface

// File: rtl/tt_bitwise_lane_unit.sv
// Registered bitwise lane: eight selectable ops, multi-beat reduction over a packet,
// result registered together with its zero flag, popcount and saturating beat count.
module tt_bitwise_lane_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tt_bitwise_lane_unit_if.slave bus
);
    localparam int PCW = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, ACCUM} state_e;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic [2:0]       op);
        case (op_e'(op))
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_NAND: return ~(x & y);
            OP_NOR:  return ~(x | y);
            OP_XNOR: return ~(x ^ y);
            OP_ANDN: return x & ~y;
            default: return x;
        endcase
    endfunction

    function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + PCW'(v[i]);
        return n;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_zero_q, out_zero_d;
    logic [PCW-1:0]   out_popcnt_q, out_popcnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] op_x, op_y, result;
    logic [CNT_W-1:0] cnt_next;

    // A stalled result blocks new beats, which freezes acc and state for free.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Mid-packet the accumulator takes the X slot and in_a moves to Y; in_b is unused.
    assign op_x     = (state_q == IDLE) ? bus.in_a : acc_q;
    assign op_y     = (state_q == IDLE) ? bus.in_b : bus.in_a;
    assign result   = apply_op(op_x, op_y, bus.in_op);
    assign cnt_next = (state_q == IDLE) ? CNT_W'(1)
                    : (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned; otherwise synthesis would infer a latch to hold it.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_zero_d   = out_zero_q;
        out_popcnt_d = out_popcnt_q;
        out_count_d  = out_count_q;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        if (accept) begin
            if (bus.in_last) begin
                out_valid_d  = 1'b1;
                out_data_d   = result;
                out_zero_d   = (result == '0);
                out_popcnt_d = popcount(result);
                out_count_d  = cnt_next;
                state_d      = IDLE;
            end else begin
                acc_d   = result;
                cnt_d   = cnt_next;
                state_d = ACCUM;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // its _d from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_zero_q   <= 1'b1;
            out_popcnt_q <= '0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_zero_q   <= out_zero_d;
            out_popcnt_q <= out_popcnt_d;
            out_count_q  <= out_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_popcnt = out_popcnt_q;
    assign bus.out_count  = out_count_q;
endmodule

// File: tb/tb_tt_bitwise_lane_unit.sv
// Directed bench for tt_bitwise_lane_unit: ops, accumulation, backpressure,
// mid-packet reset and beat-count saturation with hand-computed expectations.
module tb_tt_bitwise_lane_unit;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tt_bitwise_lane_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    tt_bitwise_lane_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_last  = last;
    endtask

    task automatic check_out(input string tag, input logic [7:0] data, input logic zero,
                             input logic [3:0] pc, input logic [3:0] cnt);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".data"},  32'(bus.out_data),  32'(data));
        check({tag, ".zero"},  32'(bus.out_zero),  32'(zero));
        check({tag, ".pop"},   32'(bus.out_popcnt), 32'(pc));
        check({tag, ".count"}, 32'(bus.out_count), 32'(cnt));
    endtask

    logic [7:0] sweep_exp [8] = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'h88, 8'hCA};
    logic [3:0] sweep_pc  [8] = '{4'd2, 4'd6, 4'd4, 4'd6, 4'd2, 4'd4, 4'd2, 4'd4};

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset values
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.data",  32'(bus.out_data),  32'h0);
        check("rst.zero",  32'(bus.out_zero),  32'd1);
        check("rst.pop",   32'(bus.out_popcnt), 32'd0);
        check("rst.count", 32'(bus.out_count), 32'd0);
        check("rst.ready", 32'(bus.in_ready),  32'd1);
        tick();

        // Single AND beat
        drive(8'hF0, 8'h3C, 3'b000, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check_out("and", 8'h30, 1'b0, 4'd2, 4'd1);
        tick();
        check("and.retire", 32'(bus.out_valid), 32'd0);

        // Op sweep, one beat per cycle with no bubbles
        for (int op = 0; op < 8; op++) begin
            drive(8'hCA, 8'h53, 3'(op), 1'b1);
            tick();
            check_out($sformatf("sweep%0d", op), sweep_exp[op], 1'b0, sweep_pc[op], 4'd1);
            check($sformatf("sweep%0d.ready", op), 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("sweep.retire", 32'(bus.out_valid), 32'd0);

        // XOR accumulation over two beats; in_b of the second beat must be ignored
        drive(8'h0F, 8'hF0, 3'b010, 1'b0);
        tick();
        check("xacc.nobeat", 32'(bus.out_valid), 32'd0);
        drive(8'hFF, 8'h55, 3'b010, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check_out("xacc", 8'h00, 1'b1, 4'd0, 4'd2);
        tick();
        check("xacc.single", 32'(bus.out_valid), 32'd0);

        // Backpressure: result held, next beat waits, then retire + accept together
        bus.out_ready = 1'b0;
        drive(8'hCA, 8'h53, 3'b000, 1'b1);
        tick();
        drive(8'hF0, 8'h3C, 3'b001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d.ready", i), 32'(bus.in_ready), 32'd0);
            check_out($sformatf("bp%0d", i), 8'h42, 1'b0, 4'd2, 4'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.ready_up", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_out("bp.swap", 8'hFC, 1'b0, 4'd6, 4'd1);
        tick();
        check("bp.retire", 32'(bus.out_valid), 32'd0);

        // Reset mid-packet discards the partial result
        drive(8'hFF, 8'h00, 3'b111, 1'b0);
        tick();
        drive(8'hFF, 8'h00, 3'b111, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst.valid", 32'(bus.out_valid), 32'd0);
        check("mrst.count", 32'(bus.out_count), 32'd0);
        drive(8'h0C, 8'h0A, 3'b001, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check_out("mrst", 8'h0E, 1'b0, 4'd3, 4'd1);
        tick();

        // Saturation: 19 non-last beats + 1 last, pass-X keeps the first operand
        for (int i = 0; i < 19; i++) begin
            drive((i == 0) ? 8'h5A : 8'(8'h10 + i), 8'hFF, 3'b111, 1'b0);
            tick();
            check($sformatf("sat%0d.nobeat", i), 32'(bus.out_valid), 32'd0);
        end
        drive(8'hA5, 8'h00, 3'b111, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check_out("sat", 8'h5A, 1'b0, 4'd4, 4'd15);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
